// File: rtl/modn_cnt_pkg.sv
// Shared constants and the modulus legality helper for the modulo-N up/down counter.
// Consumers: modn_cnt_next, modn_updn_cnt (optional down path via MODN_CNT_DOWN_EN).
package modn_cnt_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_MOD   = 12;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // The width cap keeps the 1 << width term inside a 32-bit int.
    function automatic bit mod_legal(input int width, input int modulus);
        return (width >= 1) && (width <= 30) &&
               (modulus >= 2) && (modulus <= (1 << width));
    endfunction

endpackage

// File: rtl/modn_cnt_next.sv
// Combinational next-count, wrap and terminal-count logic for one counter digit.
// The down-count path is built only when MODN_CNT_DOWN_EN is defined.
module modn_cnt_next
    import modn_cnt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MOD   = DEF_MOD
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap_nxt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

    logic dir;
    logic at_max;

    assign at_max = (cnt == MAX_V);

`ifdef MODN_CNT_DOWN_EN
    logic at_zero;

    assign dir     = up_dn;
    assign at_zero = (cnt == '0);
    assign tc      = en && (((dir == CNT_UP) && at_max) || ((dir == CNT_DN) && at_zero));
`else
    // Without the down path the direction input has no load; keep it visibly consumed.
    logic unused_up_dn;

    assign unused_up_dn = up_dn;
    assign dir          = CNT_UP;
    assign tc           = en && at_max;
`endif

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        nxt      = cnt;
        wrap_nxt = 1'b0;
        if (en) begin
            if (dir == CNT_UP) begin
                nxt      = at_max ? '0 : cnt + WIDTH'(1);
                wrap_nxt = at_max;
            end
`ifdef MODN_CNT_DOWN_EN
            else begin
                nxt      = at_zero ? MAX_V : cnt - WIDTH'(1);
                wrap_nxt = at_zero;
            end
`endif
        end
    end

endmodule

// File: rtl/modn_updn_cnt.sv
// Loadable modulo-MOD up/down counter with illegal-state recovery and cascade tc.
// Define MODN_CNT_DOWN_EN to build the down-count path; otherwise up_dn is ignored.
module modn_updn_cnt
    import modn_cnt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MOD   = DEF_MOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    generate
        if (!mod_legal(WIDTH, MOD)) begin : g_bad_mod
            $error("modn_updn_cnt: MOD=%0d is not legal for WIDTH=%0d", MOD, WIDTH);
        end
    endgenerate

    // One extra bit so MOD == 2**WIDTH is representable in the range compares.
    localparam logic [WIDTH:0] MOD_X = (WIDTH + 1)'(MOD);

    logic             out_legal;
    logic             in_legal;
    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_nxt;
    logic             tc_raw;

    assign out_legal = ({1'b0, out} < MOD_X);
    assign in_legal  = ({1'b0, in} < MOD_X);

    modn_cnt_next #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_next (
        .cnt      (out),
        .en       (en),
        .up_dn    (up_dn),
        .nxt      (cnt_nxt),
        .wrap_nxt (wrap_nxt),
        .tc       (tc_raw)
    );

    // A pending load suppresses the carry so the next stage does not step alongside it.
    assign tc = tc_raw && !load && out_legal;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out      <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (!out_legal) begin
            out      <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            out      <= in_legal ? in : '0;
            wrap     <= 1'b0;
            load_err <= !in_legal;
        end else begin
            out      <= cnt_nxt;
            wrap     <= wrap_nxt;
            load_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_modn_updn_cnt.sv
// Self-checking bench for modn_updn_cnt: vector table, directed corner sequences,
// a two-digit cascade and randomized stimulus against an arithmetic reference model.
module tb_modn_updn_cnt;

    localparam int W = 4;
    localparam int M = 12;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] din;
    logic         en;
    logic         up_dn;
    logic [W-1:0] out;
    logic         tc;
    logic         wrap;
    logic         load_err;

    logic         c_en;
    logic [3:0]   u_out, t_out;
    logic         u_tc, t_tc, u_wrap, t_wrap, u_err, t_err;

    int total = 0;
    int bad   = 0;

    modn_updn_cnt #(.WIDTH(W), .MOD(M)) dut (
        .clk(clk), .rst(rst), .load(load), .in(din), .en(en), .up_dn(up_dn),
        .out(out), .tc(tc), .wrap(wrap), .load_err(load_err)
    );

    modn_updn_cnt #(.WIDTH(4), .MOD(10)) u_units (
        .clk(clk), .rst(rst), .load(1'b0), .in(4'd0), .en(c_en), .up_dn(1'b1),
        .out(u_out), .tc(u_tc), .wrap(u_wrap), .load_err(u_err)
    );

    modn_updn_cnt #(.WIDTH(4), .MOD(6)) u_tens (
        .clk(clk), .rst(rst), .load(1'b0), .in(4'd0), .en(u_tc), .up_dn(1'b1),
        .out(t_out), .tc(t_tc), .wrap(t_wrap), .load_err(t_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         rst;
        logic         load;
        logic [W-1:0] din;
        logic         en;
        logic         up_dn;
        logic         tc;
        logic [W-1:0] out;
        logic         wrap;
        logic         err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic [W-1:0] d,
                         input logic e, input logic u);
        rst   = r;
        load  = l;
        din   = d;
        en    = e;
        up_dn = u;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state, advanced with plain modular arithmetic.
    int   m_out;
    logic m_wrap;
    logic m_err;

    function automatic logic eff_dir(input logic u);
`ifdef MODN_CNT_DOWN_EN
        return u;
`else
        return 1'b1;
`endif
    endfunction

    initial begin
        int dn_exp[4];
        logic r, l, e, u, exp_tc;
        logic [W-1:0] d;

        drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
        c_en = 1'b0;
        step();
        step();
        check("reset_out", out, 0);
        check("reset_wrap", wrap, 0);
        check("reset_err", load_err, 0);
        check("reset_tc", tc, 0);

        // rst load din en up | tc | out wrap err
        vecs[0]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 4'd7,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 4'd5,  1'b0, 1'b1, 1'b0, 4'd5,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 4'd13, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 4'd11, 1'b0, 1'b1, 1'b0, 4'd11, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd11, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd0,  1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd1,  1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'd11, 1'b0, 1'b1, 1'b0, 4'd11, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 4'd3,  1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd1,  1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].load, vecs[i].din, vecs[i].en, vecs[i].up_dn);
            #1;
            check($sformatf("vec%0d_tc", i), tc, vecs[i].tc);
            step();
            check($sformatf("vec%0d_out", i), out, vecs[i].out);
            check($sformatf("vec%0d_wrap", i), wrap, vecs[i].wrap);
            check($sformatf("vec%0d_err", i), load_err, vecs[i].err);
        end

        // Up count from reset across the 11 -> 0 roll-over.
        drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
        step();
        step();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 1; i <= 14; i++) begin
            #1;
            check($sformatf("up%0d_tc", i), tc, ((i - 1) % M) == M - 1);
            step();
            check($sformatf("up%0d_out", i), out, i % M);
            check($sformatf("up%0d_wrap", i), wrap, i == M);
        end

        // Down count from 2 through the 0 -> 11 roll-over (ignored without the down path).
        drive(1'b0, 1'b1, 4'd2, 1'b0, 1'b1);
        step();
        check("dn_load_out", out, 2);
`ifdef MODN_CNT_DOWN_EN
        dn_exp = '{1, 0, 11, 10};
`else
        dn_exp = '{3, 4, 5, 6};
`endif
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            int prev;
            prev = (i == 0) ? 2 : dn_exp[i - 1];
            #1;
`ifdef MODN_CNT_DOWN_EN
            check($sformatf("dn%0d_tc", i), tc, prev == 0);
`else
            check($sformatf("dn%0d_tc", i), tc, 0);
`endif
            step();
            check($sformatf("dn%0d_out", i), out, dn_exp[i]);
`ifdef MODN_CNT_DOWN_EN
            check($sformatf("dn%0d_wrap", i), wrap, prev == 0);
`else
            check($sformatf("dn%0d_wrap", i), wrap, 0);
`endif
        end

        // Illegal-state recovery: forced out-of-range value clears regardless of load/en.
        drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        force dut.out = 4'd14;
        #1;
        check("rec_tc_dn", tc, 0);
        up_dn = 1'b1;
        #1;
        check("rec_tc_up", tc, 0);
        drive(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
        step();
        check("rec_wrap", wrap, 0);
        check("rec_err", load_err, 0);
        release dut.out;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step();
        check("rec_out", out, 0);
        check("rec_err2", load_err, 0);

        // Two-digit cascade: units (mod 10) carry drives tens (mod 6).
        drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        c_en = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step();
            check($sformatf("cas%0d_units", k), u_out, k % 10);
            check($sformatf("cas%0d_tens", k), t_out, (k / 10) % 6);
            if (k == 59) begin
                check("cas59_units_tc", u_tc, 1);
                check("cas59_tens_tc", t_tc, 1);
            end
            if (k == 60) begin
                check("cas60_tens_wrap", t_wrap, 1);
                check("cas60_units_wrap", u_wrap, 1);
            end
        end
        check("cas_units_err", u_err, 0);
        check("cas_tens_err", t_err, 0);
        c_en = 1'b0;

        // Randomized stimulus against the reference model.
        drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
        step();
        m_out  = 0;
        m_wrap = 1'b0;
        m_err  = 1'b0;
        for (int n = 0; n < 500; n++) begin
            r = ($urandom_range(0, 39) == 0);
            l = ($urandom_range(0, 5) == 0);
            d = W'($urandom_range(0, 15));
            e = ($urandom_range(0, 3) != 0);
            u = 1'($urandom_range(0, 1));
            drive(r, l, d, e, u);
            #1;
            exp_tc = e && !l && (eff_dir(u) ? (m_out == M - 1) : (m_out == 0));
            check($sformatf("rnd%0d_tc", n), tc, exp_tc);
            if (r) begin
                m_out  = 0;
                m_wrap = 1'b0;
                m_err  = 1'b0;
            end else if (l) begin
                m_wrap = 1'b0;
                m_err  = (int'(d) >= M);
                m_out  = m_err ? 0 : int'(d);
            end else if (e) begin
                m_err = 1'b0;
                if (eff_dir(u)) begin
                    m_wrap = (m_out + 1 == M);
                    m_out  = (m_out + 1) % M;
                end else begin
                    m_wrap = (m_out == 0);
                    m_out  = (m_out + M - 1) % M;
                end
            end else begin
                m_wrap = 1'b0;
                m_err  = 1'b0;
            end
            step();
            check($sformatf("rnd%0d_out", n), out, m_out);
            check($sformatf("rnd%0d_wrap", n), wrap, m_wrap);
            check($sformatf("rnd%0d_err", n), load_err, m_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
